bcd_up_counter_2d: RTL and testbench

BCD_UP_COUNTER_2D -- requirements
Module: bcd_up_counter_2d

---
 rtl/bcd_up_counter_2d.sv | 95 +++++++++
 tb/tb_bcd_up_counter_2d.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bcd_up_counter_2d.sv
// Two-digit BCD up-counter with synchronous clear/load, programmable modulus,
// cascadable combinational terminal count and registered wrap / load-error pulses.
module bcd_up_counter_2d #(
  parameter int MODULUS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tc,
  output logic       wrap,
  output logic       load_err
);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("bcd_up_counter_2d: MODULUS must be in 2..100");
  end

  localparam logic [3:0] MAX_TENS = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((MODULUS - 1) % 10);
  localparam logic [7:0] MAX_VAL  = 8'(MODULUS - 1);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       wrap_q, wrap_d;
  logic       load_err_q, load_err_d;

  logic [7:0] load_dec;
  logic       load_ok;
  logic       at_max;

  // Control priority each edge: clr > load > en > hold. A rejected load still
  // takes its priority slot, so en is ignored in that cycle.
  always_comb begin
    load_dec   = 8'(load_val[7:4]) * 8'd10 + 8'(load_val[3:0]);
    load_ok    = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                 (load_dec <= MAX_VAL);
    at_max     = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);

    ones_d     = ones_q;
    tens_d     = tens_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;

    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (load) begin
      if (load_ok) begin
        tens_d = load_val[7:4];
        ones_d = load_val[3:0];
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (at_max) begin
        ones_d = 4'd0;
        tens_d = 4'd0;
        wrap_d = 1'b1;
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // tc only announces an increment that will really happen this edge, so a
  // downstream stage can use it directly as its count enable.
  assign tc       = en && !clr && !load && !rst && at_max;
  assign ones     = ones_q;
  assign tens     = tens_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_up_counter_2d.sv
// Bench for bcd_up_counter_2d: one MODULUS=100 and one MODULUS=60 instance share
// stimulus; a driver queues expected results and a monitor checks each cycle.
module tb_bcd_up_counter_2d;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic       load;
  logic [7:0] load_val;

  logic [3:0] ones, tens, ones60, tens60;
  logic       tc, wrap, load_err, tc60, wrap60, load_err60;

  int errors = 0;
  int checks = 0;

  // {sel, tc} checked before the edge; {sel, wrap, load_err, tens, ones} after it.
  logic [1:0]  tc_q[$];
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_up_counter_2d #(.MODULUS(100)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .ones(ones), .tens(tens), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  bcd_up_counter_2d #(.MODULUS(60)) dut60 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .ones(ones60), .tens(tens60), .tc(tc60), .wrap(wrap60), .load_err(load_err60)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int n);
    logic [3:0] t, o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  // Driver: apply inputs for the next edge and queue the expected response.
  task automatic step(input logic sel, input logic e, input logic c, input logic l,
                      input logic [7:0] lv, input logic x_tc, input logic [7:0] x_bcd,
                      input logic x_wrap, input logic x_err);
    @(negedge clk);
    en       = e;
    clr      = c;
    load     = l;
    load_val = lv;
    tc_q.push_back({sel, x_tc});
    exp_q.push_back({sel, x_wrap, x_err, x_bcd});
  endtask

  // Monitor: tc is checked mid-low-phase, registered outputs just after the edge.
  initial begin
    logic [1:0]  te;
    logic [10:0] oe;
    forever begin
      @(negedge clk);
      #2;
      if (tc_q.size() > 0) begin
        te = tc_q.pop_front();
        check(te[1] ? "tc_m60" : "tc_m100", 16'(te[1] ? tc60 : tc), 16'(te[0]));
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        oe = exp_q.pop_front();
        if (oe[10])
          check("out_m60", 16'({wrap60, load_err60, tens60, ones60}), 16'(oe[9:0]));
        else
          check("out_m100", 16'({wrap, load_err, tens, ones}), 16'(oe[9:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00;
    #2;
    check("reset_async", 16'({tens, ones, wrap, load_err, tc}), 16'h0);
    @(posedge clk); #1;
    check("reset_hold", 16'({tens, ones, wrap, load_err, tc}), 16'h0);
    check("reset_m60", 16'({tens60, ones60, wrap60, load_err60, tc60}), 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Full sweep 00..99 -> 00: tc only at 99, wrap only after 99->00.
    for (int i = 0; i < 100; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, i == 99, bcd((i + 1) % 100), i == 99, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0);

    // Load beats en; then count on from the loaded value.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h47, 1'b0, 8'h47, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h48, 1'b0, 1'b0);

    // Rejected loads: count unchanged, en ignored, one load_err pulse each.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h3A, 1'b0, 8'h48, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 8'h48, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h48, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h48, 1'b0, 1'b0);

    // clr wins over load and en at 25.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h25, 1'b0, 8'h25, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0);

    // Max-value load, wrap from 99, tc suppressed while load is high at 99.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 8'h99, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 8'h99, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h9F, 1'b0, 8'h10, 1'b0, 1'b1);

    // Asynchronous reset between edges at 73, held across an edge with en high.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h73, 1'b0, 8'h73, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_mid_cycle", 16'({tens, ones, wrap, load_err}), 16'h0);
    check("rst_mid_tc", 16'(tc), 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0);

    // MODULUS=60 instance.
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h58, 1'b0, 8'h58, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h59, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h59, 1'b0, 8'h59, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h60, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h59, 1'b0, 8'h59, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h59, 1'b0, 1'b0);

    @(posedge clk); #3;
    check("queue_drained", 16'(tc_q.size() + exp_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
